// File: rtl/vga_rect_fill.sv
// Memory-mapped rectangle fill engine: the CPU programs the geometry and colour, then the
// engine streams clipped pixel writes to the framebuffer, one per cycle when ready.
module vga_rect_fill #(
  parameter logic [7:0] BASE_ADDR = 8'he4,
  parameter int         FB_W      = 320,
  parameter int         FB_H      = 240
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        data_w_i,
  output logic        data_access_o,
  output logic [16:0] fb_addr_o,
  output logic [3:0]  fb_data_o,
  output logic        fb_we_o,
  input  logic        fb_ready_i,
  output logic        irq_o
);

  localparam logic [9:0]  FB_W10 = 10'(FB_W);
  localparam logic [9:0]  FB_H10 = 10'(FB_H);
  localparam logic [16:0] FB_W17 = 17'(FB_W);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_RUN, S_DONE} state_t;
  state_t state;

  logic [8:0]  x0_reg, w_reg;
  logic [7:0]  y0_reg, h_reg;
  logic [3:0]  color_reg;
  logic        irq_en, done;

  logic [8:0]  wx0, ww;
  logic [7:0]  wy0, wh;
  logic [3:0]  wcolor;
  logic [9:0]  xe, ye, x, y;
  logic [16:0] row_base;

  logic        bus_wr, ctrl_wr, start, busy, clip_empty;
  logic [7:0]  offset;
  logic [9:0]  x_sum, y_sum, xe_next, ye_next, x_inc, y_inc;
  logic [16:0] first_row, start_addr;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign data_access_o = (addr_i[31:24] == BASE_ADDR);
  assign offset        = addr_i[7:0];
  assign bus_wr        = data_access_o && data_w_i;
  assign ctrl_wr       = bus_wr && (offset == 8'h00);
  assign busy          = (state != S_IDLE);
  assign start         = ctrl_wr && data_i[0] && !busy;
  assign unused_bits   = ^{addr_i[23:8], data_i[31:9]};

  // Clip bounds use 10-bit sums so X0+W or Y0+H can never wrap
  assign x_sum      = {1'b0, wx0} + {1'b0, ww};
  assign y_sum      = {2'b0, wy0} + {2'b0, wh};
  assign xe_next    = (x_sum > FB_W10) ? FB_W10 : x_sum;
  assign ye_next    = (y_sum > FB_H10) ? FB_H10 : y_sum;
  assign clip_empty = (ww == 9'd0) || (wh == 8'd0) ||
                      ({1'b0, wx0} >= FB_W10) || ({2'b0, wy0} >= FB_H10);
  assign first_row  = 17'(wy0) * FB_W17;
  assign start_addr = first_row + 17'(wx0);
  assign x_inc      = x + 10'd1;
  assign y_inc      = y + 10'd1;

  always_comb begin
    rd_val = '0;
    case (offset)
      8'h00:   rd_val = {29'b0, irq_en, done, busy};
      8'h04:   rd_val = {23'b0, x0_reg};
      8'h08:   rd_val = {24'b0, y0_reg};
      8'h0C:   rd_val = {23'b0, w_reg};
      8'h10:   rd_val = {24'b0, h_reg};
      8'h14:   rd_val = {28'b0, color_reg};
      default: rd_val = '0;
    endcase
  end

  // Register file, read port and sticky DONE; a DONE set beats a same-cycle DONE_CLR
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o    <= '0;
      x0_reg    <= '0;
      y0_reg    <= '0;
      w_reg     <= '0;
      h_reg     <= '0;
      color_reg <= '0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      data_o <= data_access_o ? rd_val : 32'd0;
      if (bus_wr && !busy) begin
        case (offset)
          8'h04:   x0_reg    <= data_i[8:0];
          8'h08:   y0_reg    <= data_i[7:0];
          8'h0C:   w_reg     <= data_i[8:0];
          8'h10:   h_reg     <= data_i[7:0];
          8'h14:   color_reg <= data_i[3:0];
          default: ;
        endcase
      end
      if (ctrl_wr)
        irq_en <= data_i[2];
      if (state == S_DONE)
        done <= 1'b1;
      else if (ctrl_wr && (data_i[1] || start))
        done <= 1'b0;
      irq_o <= done && irq_en;
    end
  end

  // Fill engine; addresses advance incrementally, with row_base tracking y*FB_W
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      wx0       <= '0;
      wy0       <= '0;
      ww        <= '0;
      wh        <= '0;
      wcolor    <= '0;
      xe        <= '0;
      ye        <= '0;
      x         <= '0;
      y         <= '0;
      row_base  <= '0;
      fb_addr_o <= '0;
      fb_data_o <= '0;
      fb_we_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            wx0    <= x0_reg;
            wy0    <= y0_reg;
            ww     <= w_reg;
            wh     <= h_reg;
            wcolor <= color_reg;
            state  <= S_CLIP;
          end
        end
        S_CLIP: begin
          xe <= xe_next;
          ye <= ye_next;
          if (clip_empty) begin
            state <= S_DONE;
          end else begin
            x         <= {1'b0, wx0};
            y         <= {2'b0, wy0};
            row_base  <= first_row;
            fb_addr_o <= start_addr;
            fb_data_o <= wcolor;
            fb_we_o   <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (fb_ready_i) begin
            if (x_inc == xe) begin
              if (y_inc == ye) begin
                fb_we_o <= 1'b0;
                state   <= S_DONE;
              end else begin
                x         <= {1'b0, wx0};
                y         <= y_inc;
                row_base  <= row_base + FB_W17;
                fb_addr_o <= row_base + FB_W17 + 17'(wx0);
              end
            end else begin
              x         <= x_inc;
              fb_addr_o <= fb_addr_o + 17'd1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
